// File: rtl/data_in_pkg.sv
// Shared definitions for the router input port: flit type codes, FSM state
// encoding and the position of the destination field inside a head flit.
package data_in_pkg;

    localparam logic [1:0] FLIT_HEAD = 2'b10;
    localparam logic [1:0] FLIT_BODY = 2'b01;
    localparam logic [1:0] FLIT_TAIL = 2'b00;
    localparam logic [1:0] FLIT_IDLE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUTE = 2'd1,
        ST_SEND  = 2'd2
    } state_t;

    // The destination sits directly below the two type bits of a head flit.
    function automatic int dest_lsb(input int ll, input int dest_w);
        return ll - 2 - dest_w;
    endfunction

endpackage

// File: rtl/data_in_if.sv
// Flit link, allocator and crossbar signals of one router input port.
interface data_in_if #(
    parameter int LL     = 16,
    parameter int PTR_W  = 2,
    parameter int DEST_W = 4
);
    logic [LL-1:0]     input_data;
    logic              write_req;
    logic              write_req_ack;
    logic              alloc_req;
    logic [DEST_W-1:0] alloc_dest;
    logic              alloc_grant;
    logic [LL-1:0]     output_data;
    logic              out_valid;
    logic              out_ready;
    logic [PTR_W:0]    em_pl;
    logic              drop_err;

    modport master (
        output input_data, write_req, alloc_grant, out_ready,
        input  write_req_ack, alloc_req, alloc_dest, output_data, out_valid, em_pl, drop_err
    );

    modport slave (
        input  input_data, write_req, alloc_grant, out_ready,
        output write_req_ack, alloc_req, alloc_dest, output_data, out_valid, em_pl, drop_err
    );
endinterface

// File: rtl/data_in_flit_fifo.sv
// Circular flit buffer with occupancy count; an empty buffer presents an idle flit.
module flit_fifo
    import data_in_pkg::*;
#(
    parameter int LL    = 16,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [LL-1:0]    i_din,
    input  logic             i_pop,
    output logic [LL-1:0]    o_front,
    output logic [PTR_W:0]   o_count
);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [LL-1:0]    r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && (r_count != FULL_CNT);
    assign w_do_pop  = i_pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_front = (r_count == '0) ? {FLIT_IDLE, {(LL-2){1'b0}}} : r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/data_in.sv
// Router input port: buffers incoming flits, requests an output port for each
// head flit, then streams the packet to the crossbar until its tail leaves.
module data_in
    import data_in_pkg::*;
#(
    parameter int LL     = 16,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2,
    parameter int DEST_W = 4
) (
    input logic       clk,
    input logic       reset,
    data_in_if.slave  bus
);
    localparam int             DEST_LSB = dest_lsb(LL, DEST_W);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    state_t         r_state;
    logic           r_alloc_req;
    logic           r_drop_err;
    logic           r_head_sent;
    logic [LL-1:0]  w_front;
    logic [PTR_W:0] w_count;
    logic [1:0]     w_in_type;
    logic [1:0]     w_front_type;
    logic           w_nonempty;
    logic           w_ack;
    logic           w_push;
    logic           w_pop;
    logic           w_stray;
    logic           w_missing_tail;
    logic           w_out_valid;

    assign w_in_type    = bus.input_data[LL-1 -: 2];
    assign w_front_type = w_front[LL-1 -: 2];
    assign w_nonempty   = (w_count != '0);

    // Idle flits are acknowledged so the upstream can drop them, but never stored.
    assign w_ack  = bus.write_req && !reset && (w_count != FULL_CNT);
    assign w_push = w_ack && (w_in_type != FLIT_IDLE);

    // A head seen after this packet's own head has left means the tail went missing.
    assign w_stray        = (r_state == ST_IDLE) && w_nonempty && (w_front_type != FLIT_HEAD);
    assign w_missing_tail = (r_state == ST_SEND) && w_nonempty && r_head_sent &&
                            (w_front_type == FLIT_HEAD);
    assign w_out_valid    = (r_state == ST_SEND) && w_nonempty && !w_missing_tail;
    assign w_pop          = w_stray || (w_out_valid && bus.out_ready);

    flit_fifo #(.LL(LL), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_din   (bus.input_data),
        .i_pop   (w_pop),
        .o_front (w_front),
        .o_count (w_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_alloc_req <= 1'b0;
            r_drop_err  <= 1'b0;
            r_head_sent <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_stray) begin
                        r_drop_err <= 1'b1;
                    end else if (w_nonempty) begin
                        r_state     <= ST_ROUTE;
                        r_alloc_req <= 1'b1;
                    end
                end
                ST_ROUTE: begin
                    if (bus.alloc_grant) begin
                        r_state     <= ST_SEND;
                        r_alloc_req <= 1'b0;
                        r_head_sent <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (w_missing_tail) begin
                        r_drop_err <= 1'b1;
                        r_state    <= ST_IDLE;
                    end else if (w_out_valid && bus.out_ready) begin
                        r_head_sent <= 1'b1;
                        if (w_front_type == FLIT_TAIL) r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_alloc_req <= 1'b0;
                end
            endcase
        end
    end

    assign bus.write_req_ack = w_ack;
    assign bus.alloc_req     = r_alloc_req;
    assign bus.alloc_dest    = w_front[DEST_LSB +: DEST_W];
    assign bus.output_data   = w_front;
    assign bus.out_valid     = w_out_valid;
    assign bus.em_pl         = w_count;
    assign bus.drop_err      = r_drop_err;

endmodule

// File: tb/tb_data_in.sv
// Bench for the router input port: directed scenarios plus randomized packet
// traffic checked against an in-order packet scoreboard.
module tb_data_in;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    data_in_if #(.LL(16), .PTR_W(2), .DEST_W(4)) bus ();

    data_in #(.LL(16), .DEPTH(4), .PTR_W(2), .DEST_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got no summary, required completion");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic push_flit(input logic [15:0] f);
        int n = 0;
        @(negedge clk);
        bus.input_data = f;
        bus.write_req  = 1'b1;
        #1;
        while (!bus.write_req_ack && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (bus.write_req_ack !== 1'b1) begin
            errors++;
            $display("FAIL push_ack: flit %h ack=%b required 1", f, bus.write_req_ack);
        end
        @(posedge clk);
        #1;
        bus.write_req = 1'b0;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        bus.write_req  = 1'b1;
        bus.input_data = 16'h8001;
        #12;
        checks++; if (bus.em_pl !== 3'd0) begin errors++; $display("FAIL reset_em_pl: got %0d required 0", bus.em_pl); end
        checks++; if (bus.alloc_req !== 1'b0) begin errors++; $display("FAIL reset_alloc_req: got %b required 0", bus.alloc_req); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
        checks++; if (bus.drop_err !== 1'b0) begin errors++; $display("FAIL reset_drop_err: got %b required 0", bus.drop_err); end
        checks++; if (bus.write_req_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b required 0", bus.write_req_ack); end
        bus.write_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [15:0] got[$];
        logic [15:0] exp_f [3];
        logic [15:0] g;
        bit          granted = 0;
        exp_f = '{16'h8005, 16'h4AAA, 16'h0BBB};
        bus.out_ready = 1'b1;
        fork
            begin
                push_flit(16'h8005);
                push_flit(16'h4AAA);
                push_flit(16'h0BBB);
            end
            begin
                for (int c = 0; c < 40 && got.size() < 3; c++) begin
                    @(negedge clk);
                    #1;
                    if (bus.alloc_grant) bus.alloc_grant = 1'b0;
                    else if (bus.alloc_req && !granted) begin
                        checks++;
                        if (bus.alloc_dest !== 4'h0) begin errors++; $display("FAIL basic_dest: got %h required 0", bus.alloc_dest); end
                        granted = 1;
                        bus.alloc_grant = 1'b1;
                    end
                    if (bus.out_valid && bus.out_ready) got.push_back(bus.output_data);
                end
            end
        join
        for (int i = 0; i < 3; i++) begin
            g = (i < got.size()) ? got[i] : 16'hxxxx;
            checks++;
            if (g !== exp_f[i]) begin errors++; $display("FAIL basic_flit%0d: got %h required %h", i, g, exp_f[i]); end
        end
        @(negedge clk);
        #1;
        checks++; if (bus.em_pl !== 3'd0) begin errors++; $display("FAIL basic_em_pl: got %0d required 0", bus.em_pl); end
        checks++; if (bus.alloc_req !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_idle: req=%b valid=%b required 0 0", bus.alloc_req, bus.out_valid); end
        checks++; if (bus.drop_err !== 1'b0) begin errors++; $display("FAIL basic_drop_err: got %b required 0", bus.drop_err); end
    endtask

    task automatic test_full();
        logic [15:0] f [5];
        int          idx = 0;
        int          n = 0;
        f = '{16'h8009, 16'h4001, 16'h4002, 16'h4003, 16'h0004};
        bus.out_ready   = 1'b0;
        bus.alloc_grant = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            bus.input_data = f[idx];
            bus.write_req  = 1'b1;
            #1;
            if (bus.em_pl == 3'd4) begin
                checks++;
                if (bus.write_req_ack !== 1'b0) begin errors++; $display("FAIL full_ack: got %b required 0 at em_pl=4", bus.write_req_ack); end
            end
            if (bus.write_req_ack) idx++;
        end
        checks++; if (idx != 4) begin errors++; $display("FAIL full_accepted: got %0d required 4", idx); end
        checks++; if (bus.em_pl !== 3'd4) begin errors++; $display("FAIL full_em_pl: got %0d required 4", bus.em_pl); end
        checks++; if (bus.alloc_req !== 1'b1) begin errors++; $display("FAIL full_alloc_req: got %b required 1", bus.alloc_req); end
        @(negedge clk);
        bus.alloc_grant = 1'b1;
        @(negedge clk);
        bus.alloc_grant = 1'b0;
        bus.out_ready   = 1'b1;
        #1;
        checks++; if (bus.write_req_ack !== 1'b0 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL full_send: ack=%b valid=%b required 0 1", bus.write_req_ack, bus.out_valid); end
        @(negedge clk);
        #1;
        checks++; if (bus.em_pl !== 3'd3) begin errors++; $display("FAIL full_after_pop: em_pl=%0d required 3", bus.em_pl); end
        checks++; if (bus.write_req_ack !== 1'b1) begin errors++; $display("FAIL full_ack_return: got %b required 1", bus.write_req_ack); end
        @(negedge clk);
        bus.write_req = 1'b0;
        while ((bus.em_pl != 3'd0 || bus.out_valid) && n < 20) begin
            @(negedge clk);
            n++;
        end
        #1;
        checks++; if (bus.em_pl !== 3'd0 || bus.alloc_req !== 1'b0) begin errors++; $display("FAIL full_drain: em_pl=%0d req=%b required 0 0", bus.em_pl, bus.alloc_req); end
        checks++; if (bus.drop_err !== 1'b0) begin errors++; $display("FAIL full_drop_err: got %b required 0", bus.drop_err); end
    endtask

    task automatic test_idle_flit();
        @(negedge clk);
        bus.input_data = 16'hFFFF;
        bus.write_req  = 1'b1;
        #1;
        checks++; if (bus.write_req_ack !== 1'b1) begin errors++; $display("FAIL idle_ack: got %b required 1", bus.write_req_ack); end
        @(negedge clk);
        bus.write_req = 1'b0;
        #1;
        checks++; if (bus.em_pl !== 3'd0) begin errors++; $display("FAIL idle_em_pl: got %0d required 0", bus.em_pl); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus.alloc_req !== 1'b0) begin errors++; $display("FAIL idle_alloc_req: got %b required 0", bus.alloc_req); end
    endtask

    task automatic test_drop();
        push_flit(16'h4001);
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.em_pl !== 3'd0) begin errors++; $display("FAIL drop_em_pl: got %0d required 0", bus.em_pl); end
        checks++; if (bus.drop_err !== 1'b1) begin errors++; $display("FAIL drop_err_set: got %b required 1", bus.drop_err); end
        checks++; if (bus.alloc_req !== 1'b0) begin errors++; $display("FAIL drop_alloc_req: got %b required 0", bus.alloc_req); end
        repeat (5) @(negedge clk);
        #1;
        checks++; if (bus.drop_err !== 1'b1) begin errors++; $display("FAIL drop_err_sticky: got %b required 1", bus.drop_err); end
        apply_reset();
        #1;
        checks++; if (bus.drop_err !== 1'b0) begin errors++; $display("FAIL drop_err_cleared: got %b required 0", bus.drop_err); end
    endtask

    task automatic test_missing_tail();
        logic [15:0] got[$];
        logic [15:0] g0, g1;
        bit          granted = 0;
        bit          prev_req = 0;
        int          n_req = 0;
        bus.out_ready = 1'b1;
        fork
            begin
                push_flit(16'h8C03);
                push_flit(16'h4111);
                push_flit(16'h9C07);
            end
            begin
                for (int c = 0; c < 60 && n_req < 2; c++) begin
                    @(negedge clk);
                    #1;
                    if (bus.alloc_grant) bus.alloc_grant = 1'b0;
                    else if (bus.alloc_req && !granted) begin
                        checks++;
                        if (bus.alloc_dest !== 4'h3) begin errors++; $display("FAIL mt_first_dest: got %h required 3", bus.alloc_dest); end
                        granted = 1;
                        bus.alloc_grant = 1'b1;
                    end
                    if (bus.alloc_req && !prev_req) n_req++;
                    prev_req = bus.alloc_req;
                    if (bus.out_valid && bus.out_ready) got.push_back(bus.output_data);
                end
            end
        join
        g0 = (got.size() > 0) ? got[0] : 16'hxxxx;
        g1 = (got.size() > 1) ? got[1] : 16'hxxxx;
        checks++; if (got.size() != 2) begin errors++; $display("FAIL mt_count: got %0d flits required 2", got.size()); end
        checks++; if (g0 !== 16'h8C03 || g1 !== 16'h4111) begin errors++; $display("FAIL mt_flits: got %h %h required 8c03 4111", g0, g1); end
        checks++; if (bus.drop_err !== 1'b1) begin errors++; $display("FAIL mt_drop_err: got %b required 1", bus.drop_err); end
        checks++; if (bus.alloc_req !== 1'b1 || bus.alloc_dest !== 4'h7) begin errors++; $display("FAIL mt_reroute: req=%b dest=%h required 1 7", bus.alloc_req, bus.alloc_dest); end
        checks++; if (bus.em_pl !== 3'd1) begin errors++; $display("FAIL mt_em_pl: got %0d required 1", bus.em_pl); end
        bus.alloc_grant = 1'b0;
        apply_reset();
    endtask

    task automatic test_async_reset();
        int n = 0;
        bus.out_ready   = 1'b0;
        bus.alloc_grant = 1'b0;
        push_flit(16'h8001);
        push_flit(16'h4001);
        push_flit(16'h4002);
        while (!bus.alloc_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus.alloc_grant = 1'b1;
        @(negedge clk);
        bus.alloc_grant = 1'b0;
        #1;
        checks++; if (bus.em_pl !== 3'd3 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL ar_setup: em_pl=%0d valid=%b required 3 1", bus.em_pl, bus.out_valid); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (bus.em_pl !== 3'd0) begin errors++; $display("FAIL ar_em_pl: got %0d required 0", bus.em_pl); end
        checks++; if (bus.out_valid !== 1'b0 || bus.alloc_req !== 1'b0) begin errors++; $display("FAIL ar_outputs: valid=%b req=%b required 0 0", bus.out_valid, bus.alloc_req); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] q_in[$];
        logic [15:0] q_exp[$];
        logic [3:0]  q_dest[$];
        logic [3:0]  d;
        int          nb;
        int          n_pushed = 0;
        int          n_popped = 0;
        int          n_total;
        for (int p = 0; p < 20; p++) begin
            d  = 4'($urandom_range(0, 15));
            nb = $urandom_range(0, 3);
            q_in.push_back({2'b10, d, 10'($urandom)});
            q_exp.push_back(q_in[q_in.size()-1]);
            q_dest.push_back(d);
            for (int b = 0; b <= nb; b++) begin
                if ($urandom_range(0, 3) == 0) q_in.push_back({2'b11, 14'($urandom)});
                q_in.push_back({(b == nb) ? 2'b00 : 2'b01, 14'($urandom)});
                q_exp.push_back(q_in[q_in.size()-1]);
            end
        end
        n_total = q_exp.size();
        bus.alloc_grant = 1'b0;
        fork
            begin
                int i = 0;
                for (int c = 0; c < 4000 && i < q_in.size(); c++) begin
                    @(negedge clk);
                    if ($urandom_range(0, 3) == 0) bus.write_req = 1'b0;
                    else begin
                        bus.input_data = q_in[i];
                        bus.write_req  = 1'b1;
                        #1;
                        if (bus.write_req_ack) begin
                            if (q_in[i][15:14] != 2'b11) n_pushed++;
                            i++;
                        end
                    end
                end
                @(negedge clk);
                bus.write_req = 1'b0;
            end
            begin
                for (int c = 0; c < 4000 && n_popped < n_total; c++) begin
                    @(negedge clk);
                    checks++;
                    if (bus.em_pl !== 3'(n_pushed - n_popped)) begin errors++; $display("FAIL rnd_em_pl: got %0d required %0d", bus.em_pl, n_pushed - n_popped); end
                    bus.out_ready = ($urandom_range(0, 9) < 7);
                    #1;
                    if (bus.out_valid && bus.out_ready) begin
                        checks++;
                        if (bus.output_data !== q_exp[n_popped]) begin errors++; $display("FAIL rnd_flit%0d: got %h required %h", n_popped, bus.output_data, q_exp[n_popped]); end
                        n_popped++;
                    end
                end
            end
            begin
                for (int c = 0; c < 4000 && n_popped < n_total; c++) begin
                    @(negedge clk);
                    #1;
                    if (bus.alloc_grant) bus.alloc_grant = 1'b0;
                    else if (bus.alloc_req && $urandom_range(0, 1) == 1) begin
                        checks++;
                        if (q_dest.size() == 0 || bus.alloc_dest !== q_dest[0]) begin errors++; $display("FAIL rnd_dest: got %h required %h", bus.alloc_dest, (q_dest.size() == 0) ? 4'hx : q_dest[0]); end
                        if (q_dest.size() != 0) void'(q_dest.pop_front());
                        bus.alloc_grant = 1'b1;
                    end
                end
                bus.alloc_grant = 1'b0;
            end
        join
        checks++; if (n_popped != n_total) begin errors++; $display("FAIL rnd_complete: got %0d flits required %0d", n_popped, n_total); end
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.em_pl !== 3'd0 || bus.alloc_req !== 1'b0) begin errors++; $display("FAIL rnd_end: em_pl=%0d req=%b required 0 0", bus.em_pl, bus.alloc_req); end
        checks++; if (bus.drop_err !== 1'b0) begin errors++; $display("FAIL rnd_drop_err: got %b required 0", bus.drop_err); end
    endtask

    initial begin
        reset           = 1'b1;
        bus.write_req   = 1'b0;
        bus.input_data  = 16'hFFFF;
        bus.alloc_grant = 1'b0;
        bus.out_ready   = 1'b0;
        test_reset();
        test_basic();
        test_full();
        test_idle_flit();
        test_drop();
        test_missing_tail();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
